// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory
// between the instruction-fetch (IF) and load/store (LS) requesters.
// One access is in flight at a time; read data is returned to the owner
// after a fixed memory latency.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  // instruction-fetch requester
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  // load/store requester
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wstrb,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,
  // memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_last_ls;
  logic                  r_owner_ls;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W/8-1:0]   r_mem_wstrb;
  logic                  r_if_rvalid;
  logic                  r_ls_rvalid;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_ls_rdata;
  logic                  w_if_gnt;
  logic                  w_ls_gnt;
  logic                  w_grant;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration in IDLE (gated by reset so grants are low during reset) and next state.
  always_comb begin
    w_if_gnt    = 1'b0;
    w_ls_gnt    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (RESET_N) begin
          if (if_req && (!ls_req || r_last_ls)) begin
            w_if_gnt = 1'b1;
          end else if (ls_req) begin
            w_ls_gnt = 1'b1;
          end
        end
        if (w_if_gnt || w_ls_gnt) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = r_mem_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_grant = w_if_gnt | w_ls_gnt;

  // Memory-port registers, latency counter, read-data capture and rvalid pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt       <= '0;
      r_last_ls   <= 1'b1;
      r_owner_ls  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_mem_en    <= w_grant;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      if (w_grant) begin
        r_owner_ls  <= w_ls_gnt;
        r_last_ls   <= w_ls_gnt;
        r_mem_addr  <= w_ls_gnt ? ls_addr : if_addr;
        r_mem_we    <= w_ls_gnt & ls_we;
        r_mem_wstrb <= w_ls_gnt ? ls_wstrb : '0;
        if (w_ls_gnt) begin
          r_mem_wdata <= ls_wdata;
        end
      end
      case (r_state)
        S_ISSUE: begin
          if (!r_mem_we) begin
            r_cnt <= LAT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_owner_ls) begin
              r_ls_rdata  <= mem_rdata;
              r_ls_rvalid <= 1'b1;
            end else begin
              r_if_rdata  <= mem_rdata;
              r_if_rvalid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4),
// each with a latency-modelled memory, checked every cycle against a
// transaction-timeline reference model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n     [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        ls_req    [2];
  logic        ls_we     [2];
  logic [31:0] ls_addr   [2];
  logic [31:0] ls_wdata  [2];
  logic [3:0]  ls_wstrb  [2];
  logic        ls_gnt    [2];
  logic        ls_rvalid [2];
  logic [31:0] ls_rdata  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: absolute-cycle timeline of the access in flight.
  int          idle_at   [2];
  int          en_at     [2];
  int          rv_at     [2];
  bit          last_ls   [2];
  bit          own_ls    [2];
  bit          op_we     [2];
  logic [31:0] op_addr   [2];
  logic [31:0] op_wdata  [2];
  logic [3:0]  op_wstrb  [2];
  logic [31:0] rv_data   [2];
  logic [31:0] exp_if_rd [2];
  logic [31:0] exp_ls_rd [2];
  logic [31:0] rmem      [2][256];
  bit          rwr       [2][256];
  bit          s_if_gnt  [2];
  bit          s_ls_gnt  [2];

  function automatic logic [31:0] init_val(logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h40:   return 32'hA5A5A5A5;
      default: return {a, ~a, a ^ 8'h5A, 8'hC3};
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  function automatic int lat(int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ref_rd(int u, logic [7:0] a);
    return rwr[u][a] ? rmem[u][a] : init_val(a);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : gu
    localparam int unsigned L = (g == 0) ? 1 : 4;
    logic [31:0] pipe [4];
    logic [31:0] wmem [256];
    bit          wr   [256];

    mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(L)
    ) dut (
      .CLK      (clk),
      .RESET_N  (rst_n[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_gnt   (if_gnt[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .ls_req   (ls_req[g]),
      .ls_we    (ls_we[g]),
      .ls_addr  (ls_addr[g]),
      .ls_wdata (ls_wdata[g]),
      .ls_wstrb (ls_wstrb[g]),
      .ls_gnt   (ls_gnt[g]),
      .ls_rvalid(ls_rvalid[g]),
      .ls_rdata (ls_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_wstrb(mem_wstrb[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );

    assign mem_rdata[g] = pipe[L-1];

    // Memory: read data appears exactly L cycles after mem_en, junk otherwise.
    always @(posedge clk) begin
      for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
      if (mem_en[g] && !mem_we[g])
        pipe[0] <= wr[mem_addr[g][7:0]] ? wmem[mem_addr[g][7:0]] : init_val(mem_addr[g][7:0]);
      else
        pipe[0] <= $urandom;
      if (mem_en[g] && mem_we[g]) begin
        wmem[mem_addr[g][7:0]] <= merge(wr[mem_addr[g][7:0]] ? wmem[mem_addr[g][7:0]]
                                                             : init_val(mem_addr[g][7:0]),
                                        mem_wdata[g], mem_wstrb[g]);
        wr[mem_addr[g][7:0]] <= 1'b1;
      end
    end
  end

  task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d cyc=%0d got=%h want=%h", nm, u, cyc, act, exp);
    end
  endtask

  task automatic check_unit(int u);
    bit eig;
    bit elg;
    eig = 1'b0;
    elg = 1'b0;
    if (!rst_n[u]) begin
      idle_at[u]   = cyc;
      last_ls[u]   = 1'b1;
      en_at[u]     = -1;
      rv_at[u]     = -1;
      exp_if_rd[u] = '0;
      exp_ls_rd[u] = '0;
      chk("rst_mem_we",    u, mem_we[u],    32'd0);
      chk("rst_mem_addr",  u, mem_addr[u],  32'd0);
      chk("rst_mem_wdata", u, mem_wdata[u], 32'd0);
      chk("rst_mem_wstrb", u, mem_wstrb[u], 32'd0);
    end
    if (cyc == rv_at[u]) begin
      if (own_ls[u]) exp_ls_rd[u] = rv_data[u];
      else           exp_if_rd[u] = rv_data[u];
    end
    if (rst_n[u] && cyc >= idle_at[u]) begin
      if (if_req[u] && (!ls_req[u] || last_ls[u])) eig = 1'b1;
      else if (ls_req[u])                          elg = 1'b1;
    end
    s_if_gnt[u] = if_gnt[u];
    s_ls_gnt[u] = ls_gnt[u];
    chk("if_gnt",    u, if_gnt[u],    eig);
    chk("ls_gnt",    u, ls_gnt[u],    elg);
    chk("busy",      u, busy[u],      (rst_n[u] && cyc < idle_at[u]));
    chk("mem_en",    u, mem_en[u],    (cyc == en_at[u]));
    chk("if_rvalid", u, if_rvalid[u], (cyc == rv_at[u] && !own_ls[u]));
    chk("ls_rvalid", u, ls_rvalid[u], (cyc == rv_at[u] && own_ls[u]));
    chk("if_rdata",  u, if_rdata[u],  exp_if_rd[u]);
    chk("ls_rdata",  u, ls_rdata[u],  exp_ls_rd[u]);
    if (cyc == en_at[u]) begin
      chk("mem_addr",  u, mem_addr[u],  op_addr[u]);
      chk("mem_we",    u, mem_we[u],    op_we[u]);
      chk("mem_wstrb", u, mem_wstrb[u], op_wstrb[u]);
      if (op_we[u]) begin
        chk("mem_wdata", u, mem_wdata[u], op_wdata[u]);
        rmem[u][op_addr[u][7:0]] = merge(ref_rd(u, op_addr[u][7:0]), op_wdata[u], op_wstrb[u]);
        rwr[u][op_addr[u][7:0]]  = 1'b1;
      end else begin
        rv_data[u] = ref_rd(u, op_addr[u][7:0]);
      end
    end
    if (eig || elg) begin
      last_ls[u]  = elg;
      own_ls[u]   = elg;
      op_we[u]    = elg & ls_we[u];
      op_addr[u]  = elg ? ls_addr[u] : if_addr[u];
      op_wdata[u] = ls_wdata[u];
      op_wstrb[u] = elg ? ls_wstrb[u] : 4'd0;
      en_at[u]    = cyc + 1;
      if (op_we[u]) begin
        idle_at[u] = cyc + 2;
      end else begin
        rv_at[u]   = cyc + 2 + lat(u);
        idle_at[u] = cyc + 3 + lat(u);
      end
    end
  endtask

  task automatic sample();
    #1;
    for (int u = 0; u < 2; u++) check_unit(u);
  endtask

  task automatic advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit ifr;
    bit lsr;
    bit we;
    bit e_if;
    bit e_ls;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int   order [$];
    int   seen;
    int   en_cnt;
    int   gnt_cnt;

    tbl[0] = '{1, 1, 0, 1, 0};
    tbl[1] = '{1, 1, 0, 0, 1};
    tbl[2] = '{0, 1, 1, 0, 1};
    tbl[3] = '{1, 1, 0, 1, 0};
    tbl[4] = '{1, 0, 0, 1, 0};
    tbl[5] = '{1, 1, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 0, 0};
    tbl[7] = '{1, 1, 0, 1, 0};

    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b1; if_req[u] = 1'b0; if_addr[u] = '0;
      ls_req[u] = 1'b0; ls_we[u] = 1'b0; ls_addr[u] = '0;
      ls_wdata[u] = '0; ls_wstrb[u] = '0;
      en_at[u] = -1; rv_at[u] = -1; idle_at[u] = 0;
    end

    // Reset both instances
    @(negedge clk);
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    run(2);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    run(2);

    // Table: round-robin decisions on unit 0 from fresh reset
    for (int i = 0; i < 8; i++) begin
      if_req[0]   = tbl[i].ifr;
      ls_req[0]   = tbl[i].lsr;
      ls_we[0]    = tbl[i].we;
      if_addr[0]  = $urandom_range(0, 255);
      ls_addr[0]  = $urandom_range(0, 255);
      ls_wdata[0] = $urandom;
      ls_wstrb[0] = 4'($urandom_range(1, 15));
      sample();
      chk("tbl_if_gnt", 0, if_gnt[0], tbl[i].e_if);
      chk("tbl_ls_gnt", 0, ls_gnt[0], tbl[i].e_ls);
      advance();
      if_req[0] = 1'b0; ls_req[0] = 1'b0;
      run(6);
    end

    // IF read of 0x10 with MEM_LAT=1
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    sample(); chk("t1_if_gnt", 0, if_gnt[0], 32'd1); advance();
    if_req[0] = 1'b0;
    sample();
    chk("t1_mem_en",   0, mem_en[0],   32'd1);
    chk("t1_mem_addr", 0, mem_addr[0], 32'h10);
    chk("t1_mem_we",   0, mem_we[0],   32'd0);
    advance();
    step();
    sample();
    chk("t1_if_rvalid", 0, if_rvalid[0], 32'd1);
    chk("t1_if_rdata",  0, if_rdata[0],  32'hDEADBEEF);
    advance();
    sample(); chk("t1_busy_low", 0, busy[0], 32'd0); advance();

    // LS write
    ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_addr[0] = 32'h20;
    ls_wdata[0] = 32'h12345678; ls_wstrb[0] = 4'b0011;
    sample(); chk("t2_ls_gnt", 0, ls_gnt[0], 32'd1); advance();
    ls_req[0] = 1'b0; ls_we[0] = 1'b0;
    sample();
    chk("t2_mem_en",    0, mem_en[0],    32'd1);
    chk("t2_mem_we",    0, mem_we[0],    32'd1);
    chk("t2_mem_wdata", 0, mem_wdata[0], 32'h12345678);
    chk("t2_mem_wstrb", 0, mem_wstrb[0], 32'h3);
    advance();
    sample(); chk("t2_idle", 0, busy[0], 32'd0); advance();
    run(3);

    // Both requesting continuously: strict alternation starting with IF
    if_req[0] = 1'b1; ls_req[0] = 1'b1; ls_we[0] = 1'b0;
    if_addr[0] = 32'h30; ls_addr[0] = 32'h34;
    for (int k = 0; k < 80 && order.size() < 6; k++) begin
      sample();
      if (if_gnt[0]) order.push_back(0);
      if (ls_gnt[0]) order.push_back(1);
      advance();
    end
    if_req[0] = 1'b0; ls_req[0] = 1'b0;
    run(8);
    chk("t3_grant_count", 0, order.size(), 32'd6);
    for (int k = 0; k < order.size(); k++) chk("t3_grant_order", 0, order[k], k % 2);

    // MEM_LAT=4 LS read of 0x40, IF held off while busy
    ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h40; ls_wstrb[1] = 4'b0;
    sample(); chk("t4_ls_gnt", 1, ls_gnt[1], 32'd1); advance();
    ls_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 32'h44;
    for (int k = 1; k <= 6; k++) begin
      sample();
      chk("t4_no_if_gnt", 1, if_gnt[1], 32'd0);
      if (k == 6) begin
        chk("t4_ls_rvalid", 1, ls_rvalid[1], 32'd1);
        chk("t4_ls_rdata",  1, ls_rdata[1],  32'hA5A5A5A5);
      end
      advance();
    end
    sample(); chk("t4_if_gnt_after", 1, if_gnt[1], 32'd1); advance();
    if_req[1] = 1'b0;
    run(10);

    // Reset during WAIT of an IF read
    if_req[1] = 1'b1; if_addr[1] = 32'h10;
    sample(); chk("t5_if_gnt", 1, if_gnt[1], 32'd1); advance();
    if_req[1] = 1'b0;
    run(2);
    rst_n[1] = 1'b0;
    sample();
    chk("t5_rst_busy",      1, busy[1],      32'd0);
    chk("t5_rst_mem_en",    1, mem_en[1],    32'd0);
    chk("t5_rst_if_rvalid", 1, if_rvalid[1], 32'd0);
    chk("t5_rst_if_rdata",  1, if_rdata[1],  32'd0);
    chk("t5_rst_ls_rdata",  1, ls_rdata[1],  32'd0);
    advance();
    step();
    rst_n[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (if_rvalid[1]) seen++;
      advance();
    end
    chk("t5_no_rvalid", 1, seen, 32'd0);
    if_req[1] = 1'b1; ls_req[1] = 1'b1; ls_we[1] = 1'b0;
    sample();
    chk("t5_if_first", 1, if_gnt[1], 32'd1);
    chk("t5_ls_wait",  1, ls_gnt[1], 32'd0);
    advance();
    if_req[1] = 1'b0; ls_req[1] = 1'b0;
    run(10);

    // One-cycle IF request while busy is dropped
    ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h44; ls_wstrb[0] = 4'b0;
    sample(); chk("t6_ls_gnt", 0, ls_gnt[0], 32'd1); advance();
    ls_req[0] = 1'b0; if_req[0] = 1'b1; if_addr[0] = 32'h48;
    en_cnt = 0; gnt_cnt = 0;
    sample();
    if (mem_en[0]) en_cnt++;
    if (if_gnt[0]) gnt_cnt++;
    advance();
    if_req[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (mem_en[0]) en_cnt++;
      if (if_gnt[0]) gnt_cnt++;
      advance();
    end
    chk("t6_mem_en_count", 0, en_cnt,  32'd1);
    chk("t6_if_gnt_count", 0, gnt_cnt, 32'd0);

    // Randomized traffic on both instances with occasional resets
    for (int k = 0; k < 4000; k++) begin
      for (int u = 0; u < 2; u++) begin
        if (!rst_n[u]) rst_n[u] = 1'b1;
        else if ($urandom_range(0, 399) == 0) rst_n[u] = 1'b0;
        if (if_req[u]) begin
          if (s_if_gnt[u] || $urandom_range(0, 15) == 0) if_req[u] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if_req[u]  = 1'b1;
          if_addr[u] = $urandom_range(0, 63);
        end
        if (ls_req[u]) begin
          if (s_ls_gnt[u] || $urandom_range(0, 15) == 0) ls_req[u] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          ls_req[u]   = 1'b1;
          ls_we[u]    = 1'($urandom_range(0, 1));
          ls_addr[u]  = $urandom_range(0, 63);
          ls_wdata[u] = $urandom;
          ls_wstrb[u] = 4'($urandom_range(0, 15));
        end
      end
      step();
    end
    for (int u = 0; u < 2; u++) begin
      if_req[u] = 1'b0; ls_req[u] = 1'b0; rst_n[u] = 1'b1;
    end
    run(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch requester (IF) and load/store requester (LS). The block grants one request at a time using round-robin arbitration and drives the memory port. It counts a fixed read latency and returns read data to the owning requester. It sits between the core's fetch/LSU logic and the memory module.

Parameters:
ADDR_W, 32, address width for both requesters and the memory port.
DATA_W, 32, data width; byte strobes are DATA_W/8 wide.
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET_N  in  1  asynchronous, active-low reset.
if_req  in  1  IF request; held high until if_gnt.
if_addr  in  ADDR_W  IF read address; sampled in the grant cycle.
if_gnt  out  1  one-cycle grant pulse to IF.
if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
if_rdata  out  DATA_W  IF read data.
ls_req  in  1  LS request; held high until ls_gnt.
ls_we  in  1  LS operation: 1 = write, 0 = read.
ls_addr  in  ADDR_W  LS address.
ls_wdata  in  DATA_W  LS write data.
ls_wstrb  in  DATA_W/8  LS byte enables, used for writes only.
ls_gnt  out  1  one-cycle grant pulse to LS.
ls_rvalid  out  1  one-cycle pulse; ls_rdata is valid (reads only).
ls_rdata  out  DATA_W  LS read data.
mem_en  out  1  memory access strobe, one cycle per access.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_wstrb  out  DATA_W/8  memory byte enables.
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RESET_N low, takes effect immediately):
  - State goes to IDLE.
  - All outputs are 0: gnt, rvalid, rdata, mem_* and busy.
  - Latency counter is 0.
  - Round-robin pointer last_ls = 1, so IF wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Only one request: grant it.
  - Both requesting: grant IF if last_ls = 1, else grant LS.
  - Grant is combinational in the same cycle (if_gnt/ls_gnt high for exactly that cycle).
  - On that edge, register into the mem_* output registers: address, we, wdata, wstrb, owner.
  - IF grants force mem_we = 0 and mem_wstrb = 0.
  - Update last_ls to the owner; go to ISSUE.
  - No request: stay in IDLE; mem_addr/mem_wdata hold their last values.
- ISSUE:
  - mem_en = 1 for exactly one cycle.
  - Write: go to IDLE; no rvalid is produced.
  - Read: load counter with MEM_LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata into the owner's rdata register on that edge; go to RESP.
- RESP:
  - Owner's rvalid = 1 for one cycle; go to IDLE.
  - rdata holds its value until the next capture.
- Latency (grant cycle = g):
  - mem_en at g+1.
  - rvalid at g+2+MEM_LAT.
  - Next possible grant at g+3+MEM_LAT for reads, g+2 for writes.
- Requests are ignored outside IDLE. Requesters keep req high; no grant pulse is issued until the block returns to IDLE.
- A requester that drops req before its grant is simply not granted; this is legal.
- Starvation bound: with both requesting continuously, grants alternate IF, LS, IF, ...
- Reset mid-operation (any state) aborts the access; no rvalid is ever emitted for it.
- Combinational paths: gnt may depend combinationally on req; mem_* and rvalid outputs are registered.

Test Plan:
- Reset, then if_req=1, if_addr=0x10, memory word 0x10 = 0xDEADBEEF, MEM_LAT=1 -> if_gnt at cycle 0; mem_en, mem_addr=0x10 and mem_we=0 at cycle 1; if_rvalid=1 and if_rdata=0xDEADBEEF at cycle 3; busy low at cycle 4.
- LS write: ls_we=1, ls_addr=0x20, ls_wdata=0x12345678, ls_wstrb=4'b0011 -> mem_en=1, mem_we=1 and matching mem_wdata/mem_wstrb one cycle after ls_gnt; no ls_rvalid; block is IDLE two cycles after the grant.
- if_req and ls_req held high continuously for 6 grants -> grant order IF, LS, IF, LS, IF, LS; each rvalid goes only to its owner; the other rvalid stays 0.
- MEM_LAT=4, LS read of 0x40 (holds 0xA5A5A5A5) -> ls_rvalid exactly 6 cycles after ls_gnt with data 0xA5A5A5A5; no grant pulse while busy even with if_req=1.
- RESET_N pulsed low during WAIT of an IF read -> all outputs 0 immediately; no if_rvalid afterwards; a following simultaneous request grants IF first.
- if_req asserted for one cycle while the block is busy, then dropped -> no if_gnt and no memory access for IF.
